isqrt_iter: RTL and testbench

Iterative integer square root, the inverse of the team's 128-bit pipelined squarer. Accepts a WIDTH-bit radicand and produces floor(sqrt(radicand)) and the remainder. Uses the restoring digit-by-digit method, retiring one root bit per clock. Sits beside the squarer in the arithmetic datapath, so a square/root round trip can be checked end to end.

---
 rtl/isqrt_pkg.sv | 18 +
 rtl/isqrt_if.sv | 24 ++
 rtl/isqrt_step.sv | 37 +++
 rtl/isqrt_iter.sv | 146 ++++++++++++++
 tb/tb_isqrt_iter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared constants for the iterative integer square root.
//   WIDTH_DEF    default radicand width
//   IDLE/CALC/DONE  controller state encoding
//   cnt_width()  width of the iteration counter for a given root width
package isqrt_pkg;

  localparam int WIDTH_DEF = 256;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter holds ROOT_W-1 down to 0; a one-bit counter is the floor.
  function automatic int cnt_width(input int root_w);
    return (root_w > 1) ? $clog2(root_w) : 1;
  endfunction

endpackage

// File: rtl/isqrt_if.sv
// isqrt_if: request/result bundle between a square-root user and isqrt_iter.
//   start     request pulse (master -> slave)
//   radicand  WIDTH-bit operand (master -> slave)
//   busy      operation in progress (slave -> master)
//   root      floor(sqrt(radicand)), ROOT_W bits (slave -> master)
//   rem       radicand - root^2, ROOT_W+1 bits (slave -> master)
//   done      one-cycle result-valid pulse (slave -> master)
interface isqrt_if
  import isqrt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  localparam int ROOT_W = WIDTH / 2;

  logic              start;
  logic [WIDTH-1:0]  radicand;
  logic              busy;
  logic [ROOT_W-1:0] root;
  logic [ROOT_W:0]   rem;
  logic              done;

  modport master (output start, radicand, input busy, root, rem, done);
  modport slave  (input start, radicand, output busy, root, rem, done);
endinterface

// File: rtl/isqrt_step.sv
// isqrt_step: one restoring digit-by-digit square-root iteration (combinational).
//   r, q      partial remainder (ROOT_W+2 bits) and partial root (ROOT_W bits)
//   pair      next two radicand bits, most significant first
//   r_next    updated partial remainder
//   q_next    updated partial root with the new root bit appended
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int ROOT_W = WIDTH_DEF / 2
) (
  input  logic [ROOT_W+1:0] r,
  input  logic [ROOT_W-1:0] q,
  input  logic [1:0]        pair,
  output logic [ROOT_W+1:0] r_next,
  output logic [ROOT_W-1:0] q_next
);

  logic [ROOT_W+1:0] r_shift;
  logic [ROOT_W+1:0] trial;

  // The remainder never exceeds 2*q, so the shifted value always fits in
  // ROOT_W+2 bits and the dropped top bits are zero.
  assign r_shift = (r << 2) | {{ROOT_W{1'b0}}, pair};
  assign trial   = {q, 2'b01};

  // Subtract the trial divisor when it fits and record the root bit.
  always_comb begin
    if (r_shift >= trial) begin
      r_next = r_shift - trial;
      q_next = {q[ROOT_W-2:0], 1'b1};
    end else begin
      r_next = r_shift;
      q_next = {q[ROOT_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_iter.sv
// isqrt_iter: iterative integer square root, one root bit per clock.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   isqrt_if slave: start/radicand in; busy/root/rem/done out
// Accepts a request in IDLE, runs ROOT_W iterations in CALC, and publishes
// the result on the DONE edge (done high ROOT_W+1 edges after acceptance).
// Optional: define ISQRT_SELFCHECK_EN to add a simulation-only consistency
// check of every result against a registered copy of the radicand.
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ROOT_W = WIDTH / 2
) (
  input  logic   clk,
  input  logic   rst,
  isqrt_if.slave bus
);

  localparam int CNT_W = cnt_width(ROOT_W);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [WIDTH-1:0]  x;
  logic [ROOT_W+1:0] r;
  logic [ROOT_W+1:0] r_step;
  logic [ROOT_W-1:0] q;
  logic [ROOT_W-1:0] q_step;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;
  logic              accept;
  logic              iterate;
  logic              finish;

  isqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .r      (r),
    .q      (q),
    .pair   (x[WIDTH-1:WIDTH-2]),
    .r_next (r_step),
    .q_next (q_step)
  );

  assign last_iter = (cnt == {CNT_W{1'b0}});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = bus.start ? CALC : IDLE;
      CALC:    state_next = last_iter ? DONE : CALC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    accept  = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE:    accept  = bus.start;
      CALC:    iterate = 1'b1;
      DONE:    finish  = 1'b1;
      default: begin
        accept  = 1'b0;
        iterate = 1'b0;
        finish  = 1'b0;
      end
    endcase
  end

  // Working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      r        <= '0;
      q        <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.root <= '0;
      bus.rem  <= '0;
    end else if (accept) begin
      x        <= bus.radicand;
      r        <= '0;
      q        <= '0;
      cnt      <= CNT_W'(ROOT_W - 1);
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
    end else if (iterate) begin
      x        <= {x[WIDTH-3:0], 2'b00};
      r        <= r_step;
      q        <= q_step;
      cnt      <= cnt - CNT_W'(1);
      bus.done <= 1'b0;
    end else if (finish) begin
      bus.root <= q;
      bus.rem  <= r[ROOT_W:0];
      bus.busy <= 1'b0;
      bus.done <= 1'b1;
    end else begin
      bus.done <= 1'b0;
    end
  end

`ifdef ISQRT_SELFCHECK_EN
  logic [WIDTH-1:0] rad_copy;
  logic [WIDTH-1:0] root_sq;
  logic [WIDTH:0]   recon;

  // Keep the accepted radicand; x is consumed by the shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_copy <= '0;
    end else if (accept) begin
      rad_copy <= bus.radicand;
    end else begin
      rad_copy <= rad_copy;
    end
  end

  assign root_sq = {{ROOT_W{1'b0}}, bus.root} * {{ROOT_W{1'b0}}, bus.root};
  assign recon   = {1'b0, root_sq} + {{ROOT_W{1'b0}}, bus.rem};

  // Result consistency check while done is high.
  always @(posedge clk) begin
    if (!rst && bus.done) begin
      if ((recon != {1'b0, rad_copy}) || (bus.rem > {bus.root, 1'b0})) begin
        $error("isqrt_iter result inconsistent: radicand=%0h root=%0h rem=%0h",
               rad_copy, bus.root, bus.rem);
      end
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_iter.sv
// tb_isqrt_iter: directed and random checks of isqrt_iter (WIDTH=256).
// A cycle-level protocol model computes the expected busy/done/root/rem from
// a bitwise binary-search square root; a compare process checks every cycle,
// and directed operations also check literal results and latency.
module tb_isqrt_iter;
  import isqrt_pkg::*;

  localparam int W  = 256;
  localparam int RW = 128;

  logic clk = 1'b0;
  logic rst;

  isqrt_if #(.WIDTH(W)) bus ();

  isqrt_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  // Model state.
  logic          m_busy;
  logic          m_done;
  logic [RW-1:0] m_root;
  logic [RW:0]   m_rem;
  logic [RW-1:0] e_root;
  logic [RW:0]   e_rem;
  int            m_left;

  function automatic logic [RW-1:0] ref_root(input logic [W-1:0] v);
    logic [RW-1:0] res;
    logic [RW-1:0] cand;
    logic [W-1:0]  c;
    res = '0;
    for (int b = RW - 1; b >= 0; b--) begin
      cand = res | (128'd1 << b);
      c = {128'd0, cand};
      if (c * c <= v) res = cand;
    end
    return res;
  endfunction

  function automatic logic [RW:0] ref_rem(input logic [W-1:0] v);
    logic [W-1:0] c;
    logic [W-1:0] d;
    c = {128'd0, ref_root(v)};
    d = v - c * c;
    return d[RW:0];
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Protocol model: accept in idle, result ROOT_W+1 edges later, then held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_root <= '0;
      m_rem  <= '0;
      e_root <= '0;
      e_rem  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          m_left <= RW;
          e_root <= ref_root(bus.radicand);
          e_rem  <= ref_rem(bus.radicand);
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end else begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_root <= e_root;
        m_rem  <= e_rem;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("cyc_busy", bus.busy, m_busy);
    check("cyc_done", bus.done, m_done);
    check("cyc_root", bus.root, m_root);
    check("cyc_rem",  bus.rem,  m_rem);
  end

  always @(posedge bus.done) done_pulses <= done_pulses + 1;

  // Wait (bounded) for done; returns edges counted since the caller's edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
  endtask

  // One operation, started from #1 after an edge; checks latency and literals.
  task automatic do_op(input string nm, input logic [W-1:0] v, input bit lit,
                       input logic [RW-1:0] er, input logic [RW:0] em);
    int lat;
    bus.start    = 1'b1;
    bus.radicand = v;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.radicand = rand256();
    wait_done(lat);
    check({nm, "_lat"}, lat, 129);
    check({nm, "_busy_at_done"}, bus.busy, 1'b0);
    if (lit) begin
      check({nm, "_root"}, bus.root, er);
      check({nm, "_rem"}, bus.rem, em);
    end
  endtask

  logic [RW-1:0] k;
  logic [W-1:0]  ksq;
  int            pulses;
  int            lat;

  initial begin
    bus.start    = 1'b0;
    bus.radicand = '0;
    rst          = 1'b1;

    // Pin the reference model with hand-computed values.
    check("model_9",   ref_root(256'd9), 128'd3);
    check("model_10r", ref_rem(256'd10), 129'd1);
    check("model_99",  ref_root(256'd99), 128'd9);
    check("model_max", ref_root({256{1'b1}}), {128{1'b1}});

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_root", bus.root, 128'd0);
    check("rst_rem",  bus.rem,  129'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("r9",  256'd9,  1'b1, 128'd3, 129'd0);
    do_op("r10", 256'd10, 1'b1, 128'd3, 129'd1);
    do_op("r0",  256'd0,  1'b1, 128'd0, 129'd0);
    do_op("rmax", {256{1'b1}}, 1'b1, {128{1'b1}}, {{128{1'b1}}, 1'b0});

    k   = 128'h123456789ABCDEF0123456789ABCDEF0;
    ksq = {128'd0, k} * {128'd0, k};
    do_op("rt",  ksq,          1'b1, k, 129'd0);
    do_op("rt1", ksq + 256'd1, 1'b1, k, 129'd1);

    // start with 100 while busy on 16 must be ignored.
    pulses       = done_pulses;
    bus.start    = 1'b1;
    bus.radicand = 256'd16;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.radicand = 256'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("busy_root", bus.root, 128'd4);
    check("busy_rem",  bus.rem,  129'd0);
    do_op("b2b", 256'd100, 1'b1, 128'd10, 129'd0);
    check("busy_pulses", done_pulses - pulses, 2);

    // Reset 50 cycles into an operation aborts it without a done pulse.
    bus.start    = 1'b1;
    bus.radicand = 256'd49;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_root", bus.root, 128'd0);
    check("mid_rst_rem",  bus.rem,  129'd0);
    #1;
    rst = 1'b0;
    pulses = done_pulses;
    repeat (140) @(posedge clk);
    #1;
    check("mid_rst_nodone", done_pulses - pulses, 0);
    do_op("r49", 256'd49, 1'b1, 128'd7, 129'd0);

    // Random sweep checked by the model.
    for (int i = 0; i < 40; i++) begin
      do_op("rand", rand256(), 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
